// File: rtl/game_flow_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the game:
// player/ball events in, and level/score state plus reset pulses out.
interface game_flow_if;
  logic       start_btn;
  logic       brick_hit;
  logic       ball_lost;
  logic       victory_complete;
  logic       trigger_victory;
  logic       game_reset;
  logic       ball_enable;
  logic       game_over_on;
  logic [5:0] bricks_left;
  logic [1:0] lives;
  logic [9:0] score;
  logic [2:0] state_out;

  modport master (
    input  start_btn, brick_hit, ball_lost, victory_complete,
    output trigger_victory, game_reset, ball_enable, game_over_on,
           bricks_left, lives, score, state_out
  );

  modport slave (
    output start_btn, brick_hit, ball_lost, victory_complete,
    input  trigger_victory, game_reset, ball_enable, game_over_on,
           bricks_left, lives, score, state_out
  );
endinterface

// File: rtl/game_flow_ctrl.sv
// Game sequencer: tracks bricks, lives and score, drives the victory handoff
// and issues a one-cycle game_reset between rounds.
module game_flow_ctrl #(
  parameter int NUM_BRICKS       = 40,
  parameter int START_LIVES      = 3,
  parameter int POINTS_PER_BRICK = 1
) (
  input  logic         clk,
  input  logic         reset_n,
  game_flow_if.master  gf
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_PLAYING   = 3'd1,
    S_VICTORY   = 3'd2,
    S_GAME_OVER = 3'd3,
    S_RESTART   = 3'd4
  } state_t;

  state_t      state, state_nxt;
  logic        start_btn_q;
  logic        trigger_q;
  logic        win;
  logic [5:0]  bricks_left;
  logic [1:0]  lives;
  logic [9:0]  score;

  logic        start_edge;
  logic        hit;
  logic        last_hit;
  logic [10:0] score_sum;

  assign start_edge = gf.start_btn & ~start_btn_q;
  assign hit        = gf.brick_hit && (bricks_left != 6'd0);
  assign last_hit   = gf.brick_hit && (bricks_left == 6'd1);
  assign score_sum  = {1'b0, score} + 11'(POINTS_PER_BRICK);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_edge) state_nxt = S_PLAYING;
      // The last brick outranks a simultaneous ball loss.
      S_PLAYING: begin
        if (last_hit)                              state_nxt = S_VICTORY;
        else if (gf.ball_lost && lives <= 2'd1)    state_nxt = S_GAME_OVER;
      end
      S_VICTORY:   if (gf.victory_complete) state_nxt = S_RESTART;
      S_GAME_OVER: if (start_edge)          state_nxt = S_RESTART;
      S_RESTART:   state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      start_btn_q <= 1'b0;
      trigger_q   <= 1'b0;
      win         <= 1'b0;
      bricks_left <= 6'(NUM_BRICKS);
      lives       <= 2'(START_LIVES);
      score       <= 10'd0;
    end else begin
      start_btn_q <= gf.start_btn;
      trigger_q   <= (state == S_PLAYING) && last_hit;
      case (state)
        S_PLAYING: begin
          if (hit) begin
            bricks_left <= bricks_left - 6'd1;
            score       <= (score_sum > 11'd1023) ? 10'd1023 : score_sum[9:0];
          end
          if (gf.ball_lost && !last_hit && lives != 2'd0)
            lives <= lives - 2'd1;
        end
        S_VICTORY:   if (gf.victory_complete) win <= 1'b1;
        S_GAME_OVER: if (start_edge)          win <= 1'b0;
        // A won round carries its score into the next level.
        S_RESTART: begin
          bricks_left <= 6'(NUM_BRICKS);
          lives       <= 2'(START_LIVES);
          if (!win) score <= 10'd0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    gf.ball_enable     = (state == S_PLAYING);
    gf.game_over_on    = (state == S_GAME_OVER);
    gf.game_reset      = (state == S_RESTART);
    gf.state_out       = state;
    gf.trigger_victory = trigger_q;
    gf.bricks_left     = bricks_left;
    gf.lives           = lives;
    gf.score           = score;
  end

endmodule

// File: tb/tb_game_flow_ctrl.sv
// Directed scenarios plus random play for game_flow_ctrl, checked every cycle
// against a round-level model of the game rules.
module tb_game_flow_ctrl;
  logic clk = 1'b0;
  logic reset_n;
  game_flow_if gf();

  game_flow_ctrl #(.NUM_BRICKS(40), .START_LIVES(3), .POINTS_PER_BRICK(1)) dut (
    .clk(clk), .reset_n(reset_n), .gf(gf)
  );

  always #5 clk = ~clk;

  localparam int IDLE = 0, PLAYING = 1, VICTORY = 2, GAME_OVER = 3, RESTART = 4;

  int n_asserts = 0;
  int n_fail    = 0;

  // reference model
  int  m_mode, m_bricks, m_lives, m_score;
  bit  m_won, m_btn_prev, m_trig;

  task automatic chk(input string tag, input int obs, input int exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = IDLE; m_bricks = 40; m_lives = 3; m_score = 0;
    m_won = 0; m_btn_prev = 0; m_trig = 0;
  endtask

  task automatic model_step(input bit sb, input bit bh, input bit bl, input bit vc);
    bit pressed;
    pressed    = sb && !m_btn_prev;
    m_btn_prev = sb;
    m_trig     = 0;
    case (m_mode)
      IDLE: if (pressed) m_mode = PLAYING;
      PLAYING: begin
        if (bh && m_bricks > 0) begin
          m_bricks = m_bricks - 1;
          m_score  = (m_score + 1 > 1023) ? 1023 : m_score + 1;
          if (m_bricks == 0) begin
            m_mode = VICTORY;
            m_trig = 1;
          end
        end
        if (m_mode == PLAYING && bl) begin
          m_lives = m_lives - 1;
          if (m_lives == 0) m_mode = GAME_OVER;
        end
      end
      VICTORY:   if (vc) begin m_mode = RESTART; m_won = 1; end
      GAME_OVER: if (pressed) begin m_mode = RESTART; m_won = 0; end
      default: begin
        m_bricks = 40; m_lives = 3;
        if (!m_won) m_score = 0;
        m_mode = IDLE;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"},  int'(gf.state_out),       m_mode);
    chk({tag, ".bricks"}, int'(gf.bricks_left),     m_bricks);
    chk({tag, ".lives"},  int'(gf.lives),           m_lives);
    chk({tag, ".score"},  int'(gf.score),           m_score);
    chk({tag, ".trig"},   int'(gf.trigger_victory), int'(m_trig));
    chk({tag, ".grst"},   int'(gf.game_reset),      int'(m_mode == RESTART));
    chk({tag, ".ben"},    int'(gf.ball_enable),     int'(m_mode == PLAYING));
    chk({tag, ".gover"},  int'(gf.game_over_on),    int'(m_mode == GAME_OVER));
  endtask

  // One clock: drive at negedge, model at posedge, sample 1 time unit later.
  task automatic cycle(input string tag, input bit sb, input bit bh, input bit bl, input bit vc);
    @(negedge clk);
    gf.start_btn = sb; gf.brick_hit = bh; gf.ball_lost = bl; gf.victory_complete = vc;
    @(posedge clk);
    model_step(sb, bh, bl, vc);
    #1;
    check_all(tag);
  endtask

  task automatic start_game(input string tag);
    cycle(tag, 1, 0, 0, 0);
    cycle(tag, 0, 0, 0, 0);
  endtask

  initial begin
    bit sb;
    gf.start_btn = 0; gf.brick_hit = 0; gf.ball_lost = 0; gf.victory_complete = 0;
    reset_n = 0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk); reset_n = 1;

    // 1: start edge
    cycle("t1_idle", 0, 1, 1, 0);
    cycle("t1_start", 1, 0, 0, 0);
    chk("t1_state", int'(gf.state_out), 1);
    chk("t1_bricks", int'(gf.bricks_left), 40);
    cycle("t1_hold", 1, 0, 0, 0);

    // 2: clear all 40 bricks
    for (int i = 0; i < 40; i++) begin
      cycle("t2_hit", 0, 1, 0, 0);
      if (i < 39) cycle("t2_gap", 0, 0, 0, 0);
    end
    chk("t2_trig", int'(gf.trigger_victory), 1);
    chk("t2_score", int'(gf.score), 40);
    cycle("t2_after", 0, 1, 1, 0);
    chk("t2_trig_once", int'(gf.trigger_victory), 0);

    // 3: victory hold then restart keeping score
    for (int i = 0; i < 20; i++) cycle("t3_hold", i[0], 1, 1, 0);
    cycle("t3_vc", 0, 0, 0, 1);
    chk("t3_grst", int'(gf.game_reset), 1);
    cycle("t3_idle", 0, 0, 0, 0);
    chk("t3_score", int'(gf.score), 40);
    chk("t3_bricks", int'(gf.bricks_left), 40);
    cycle("t3_idle2", 0, 0, 0, 0);

    // 4: lose all lives, restart clears score
    start_game("t4_start");
    for (int i = 0; i < 3; i++) begin
      cycle("t4_lost", 0, i == 1, 1, 0);
      cycle("t4_gap", 0, 0, 0, 0);
    end
    chk("t4_gover", int'(gf.game_over_on), 1);
    cycle("t4_press", 1, 0, 0, 0);
    chk("t4_grst", int'(gf.game_reset), 1);
    cycle("t4_idle", 0, 0, 0, 0);
    chk("t4_score", int'(gf.score), 0);

    // 5: simultaneous hit and loss
    start_game("t5_start");
    for (int i = 0; i < 39; i++) cycle("t5_hit", 0, 1, 0, 0);
    cycle("t5_both_last", 0, 1, 1, 0);
    chk("t5_lives_kept", int'(gf.lives), 3);
    cycle("t5_vc", 0, 0, 0, 1);
    cycle("t5_idle", 0, 0, 0, 0);
    start_game("t5_start2");
    for (int i = 0; i < 35; i++) cycle("t5_hit2", 0, 1, 0, 0);
    cycle("t5_both", 0, 1, 1, 0);
    chk("t5_bricks4", int'(gf.bricks_left), 4);
    chk("t5_lives2", int'(gf.lives), 2);

    // 6: async reset mid-victory
    for (int i = 0; i < 4; i++) cycle("t6_hit", 0, 1, 0, 0);
    cycle("t6_vic", 0, 0, 0, 0);
    #2 reset_n = 0;
    #1 model_reset();
    check_all("t6_async");
    chk("t6_state", int'(gf.state_out), 0);
    @(negedge clk); @(negedge clk); reset_n = 1;
    for (int i = 0; i < 4; i++) cycle("t6_post", 0, 0, 0, 1);

    // score saturation over many won levels
    for (int lvl = 0; lvl < 27; lvl++) begin
      start_game("sat_start");
      for (int i = 0; i < 40; i++) cycle("sat_hit", 0, 1, 0, 0);
      cycle("sat_vc", 0, 0, 0, 1);
      cycle("sat_idle", 0, 0, 0, 0);
    end
    chk("sat_score", int'(gf.score), 1023);

    // random play
    sb = 0;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(9) == 0) sb = ~sb;
      cycle("rand", sb, $urandom_range(2) == 0, $urandom_range(15) == 0,
            $urandom_range(7) == 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
